// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide engine (MULT, MULTU, DIV, DIVU) feeding the HI/LO registers.
// Fixed 34-cycle latency: one PREP cycle, 32 shift-add / restoring-divide steps, one FIX cycle.
module mul_div_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] opnd_q, opnd_d;
    logic [64:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul_s, is_signed_s, sign_a_s, sign_b_s;
    logic [32:0] mul_sum_s, trial_s, diff_s;
    logic [63:0] prod_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return 32'd0 - x;
    endfunction

    assign is_mul_s    = ~op_q[1];
    assign is_signed_s = ~op_q[0];
    assign sign_a_s    = is_signed_s & a_q[31];
    assign sign_b_s    = is_signed_s & b_q[31];

    // Per-iteration datapath: acc holds {33-bit upper part, 32-bit multiplier/quotient shift register}
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = acc_q[64:32] + {1'b0, opnd_q};
        end else begin
            mul_sum_s = acc_q[64:32];
        end
        trial_s = {acc_q[63:32], acc_q[31]};
        diff_s  = trial_s - {1'b0, opnd_q};
        if (neg_res_q) begin
            prod_s = 64'd0 - acc_q[63:0];
        end else begin
            prod_s = acc_q[63:0];
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                neg_res_d = sign_a_s ^ sign_b_s;
                neg_rem_d = sign_a_s;
                cnt_d     = 5'd0;
                // Multiplier (|b|) or dividend (|a|) is shifted through the low word
                if (is_mul_s) begin
                    opnd_d = sign_a_s ? neg32(a_q) : a_q;
                    acc_d  = {33'd0, (sign_b_s ? neg32(b_q) : b_q)};
                end else begin
                    opnd_d = sign_b_s ? neg32(b_q) : b_q;
                    acc_d  = {33'd0, (sign_a_s ? neg32(a_q) : a_q)};
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (is_mul_s) begin
                    acc_d = {1'b0, mul_sum_s, acc_q[31:1]};
                end else if (!diff_s[32]) begin
                    acc_d = {diff_s, acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {trial_s, acc_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                if (is_mul_s) begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end else if (b_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
                    lo_d = neg_res_q ? neg32(acc_q[31:0]) : acc_q[31:0];
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PREP) || (state_d == ST_RUN) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            opnd_q    <= 32'd0;
            acc_q     <= 65'd0;
            cnt_q     <= 5'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, ignored starts, back-to-back, reset abort.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk, nrst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit dut (
        .clk(clk), .nrst(nrst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        #3 nrst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_multu();
        int edges;
        bit busy_drop;
        busy_drop = 1'b0;
        edges = -1;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_start: got %b expected 1", busy); end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = i;
                break;
            end
            if (busy !== 1'b1) busy_drop = 1'b1;
        end
        n_checks++; if (busy_drop !== 1'b0) begin n_fail++; $display("FAIL multu_busy_hold: busy dropped before done"); end
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL multu_latency: got %0d expected 34", edges); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult();
        int edges;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL mult_neg_latency: got %0d expected 34", edges); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
        launch(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL mult_min_latency: got %0d expected 34", edges); end
        n_checks++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_div();
        int edges;
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL div_neg_latency: got %0d expected 34", edges); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_quot: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_rem: got %h expected ffffffff", hi); end
        launch(OP_DIVU, 32'd7, 32'd2);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", edges); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_quot: got %h expected 00000003", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_rem: got %h expected 00000001", hi); end
    endtask

    task automatic test_div_corner();
        int edges;
        launch(OP_DIVU, 32'h64, 32'd0);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL divu_zero_latency: got %0d expected 34", edges); end
        n_checks++; if (hi !== 32'h64) begin n_fail++; $display("FAIL divu_zero_hi: got %h expected 00000064", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
        launch(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done(edges);
        n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL div_zero_hi: got %h expected fffffffb", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero_lo: got %h expected ffffffff", lo); end
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL div_ovf_latency: got %0d expected 34", edges); end
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_quot: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_rem: got %h expected 00000000", hi); end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int first;
        ndone = 0;
        first = -1;
        launch(OP_MULTU, 32'd3, 32'd4);
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
            if (i == 10) begin
                start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
            end else if (i == 11) begin
                start = 1'b0;
            end
            if (i == 15) begin
                a = 32'hDEAD_BEEF; b = 32'h1234_5678;
            end
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        n_checks++; if (first !== 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", first); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL ignore_lo: got %h expected 0000000c", lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int e1;
        int e2;
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(e1);
        n_checks++; if (e1 !== 34) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 34", e1); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_first_quot: got %h expected 0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_first_rem: got %h expected 00000002", hi); end
        launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b expected 1", busy); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_hold_lo: got %h expected 0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hold_hi: got %h expected 00000002", hi); end
        wait_done(e2);
        n_checks++; if (e2 !== 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 34", e2); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_second_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected fffffffa", lo); end
    endtask

    task automatic test_reset_abort();
        int edges;
        bit saw_done;
        saw_done = 1'b0;
        launch(OP_DIVU, 32'h0000_1000, 32'd3);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        #2 nrst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
            if (i == 3) nrst = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 expected 0"); end
        launch(OP_MULTU, 32'd2, 32'd3);
        wait_done(edges);
        n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 34", edges); end
        n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL post_reset_lo: got %h expected 00000006", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_corner();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
